// File: rtl/pc_isp_pkg.sv
// Shared constants for the prefetch / PC / interrupt-stack path.
package pc_isp_pkg;

  // Instruction address width used by prefetch and the PC.
  localparam int DEF_MINSTW  = 8;
  // log2 of the return-stack depth.
  localparam int DEF_SDEPTHW = 3;

  // Interrupt vector address.
  localparam logic [7:0] ITRADD = 8'h02;

  // Opcodes shared with prefetch.
  localparam logic [3:0] OP_JIZ = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_CAL = 4'd7;
  localparam logic [3:0] OP_RET = 4'd8;

  // Stack operation chosen by the arbitration in pc_isp.
  typedef enum logic [1:0] {
    STK_IDLE,
    STK_PUSH,
    STK_POP,
    STK_REPL
  } stk_op_e;

endpackage

// File: rtl/pc_isp_if.sv
// Prefetch <-> PC/return-stack bus.
interface pc_isp_if
  import pc_isp_pkg::*;
#(
  parameter int MINSTW  = DEF_MINSTW,
  parameter int SDEPTHW = DEF_SDEPTHW
);
  logic [MINSTW-1:0]  instr_addr;
  logic               pc_l;
  logic               isp_push;
  logic               isp_pop;
  logic               itr;
  logic [MINSTW-1:0]  addr;
  logic [MINSTW-1:0]  ret_addr;
  logic [SDEPTHW:0]   isp_depth;
  logic               isp_ovf;
  logic               isp_unf;

  // Prefetch side.
  modport master (
    output instr_addr, pc_l, isp_push, isp_pop, itr,
    input  addr, ret_addr, isp_depth, isp_ovf, isp_unf
  );

  // PC / stack side.
  modport slave (
    input  instr_addr, pc_l, isp_push, isp_pop, itr,
    output addr, ret_addr, isp_depth, isp_ovf, isp_unf
  );
endinterface

// File: rtl/pc_isp_lifo.sv
// Return-address LIFO: register array, depth counter, full/empty and sticky flags.
module isp_lifo
  import pc_isp_pkg::*;
#(
  parameter int DW      = DEF_MINSTW,
  parameter int SDEPTHW = DEF_SDEPTHW
) (
  input  logic               clk,
  input  logic               rst,
  input  stk_op_e            op,
  input  logic [DW-1:0]      wdata,
  output logic [DW-1:0]      top,
  output logic [SDEPTHW:0]   depth,
  output logic               ovf,
  output logic               unf
);
  localparam int              DEPTH = 2**SDEPTHW;
  localparam logic [SDEPTHW:0] FULL = (SDEPTHW+1)'(DEPTH);

  logic [DW-1:0]      mem [DEPTH];
  logic [SDEPTHW:0]   depth_q;
  logic [SDEPTHW:0]   depth_m1;
  logic [SDEPTHW-1:0] top_idx;
  logic [SDEPTHW-1:0] wr_idx;
  logic               wr_en;
  logic               full;
  logic               empty;

  assign full     = (depth_q == FULL);
  assign empty    = (depth_q == '0);
  assign depth_m1 = depth_q - (SDEPTHW+1)'(1);
  assign top_idx  = depth_m1[SDEPTHW-1:0];

  // Write port: push lands above the top, replace overwrites the top (or slot 0 when empty).
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = depth_q[SDEPTHW-1:0];
    case (op)
      STK_PUSH: wr_en = !full;
      STK_REPL: begin
        wr_en = 1'b1;
        if (!empty) wr_idx = top_idx;
      end
      default: ;
    endcase
  end

  // Entry storage; not reset since depth alone decides what is visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wdata;
  end

  // Depth counter and sticky overflow/underflow flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      case (op)
        STK_PUSH: begin
          if (full) ovf <= 1'b1;
          else      depth_q <= depth_q + (SDEPTHW+1)'(1);
        end
        STK_POP: begin
          if (empty) unf <= 1'b1;
          else       depth_q <= depth_m1;
        end
        STK_REPL: begin
          if (empty) depth_q <= (SDEPTHW+1)'(1);
        end
        default: ;
      endcase
    end
  end

  assign depth = depth_q;
  assign top   = empty ? '0 : mem[top_idx];
endmodule

// File: rtl/pc_isp.sv
// Program counter register plus push/pop/interrupt arbitration for the return stack.
module pc_isp
  import pc_isp_pkg::*;
#(
  parameter int MINSTW  = DEF_MINSTW,
  parameter int SDEPTHW = DEF_SDEPTHW
) (
  input  logic      clk,
  input  logic      rst,
  pc_isp_if.slave   bus
);
  logic [MINSTW-1:0] addr_q;
  stk_op_e           op;
  logic              unused_pc_l;

  // pc_l only tells us prefetch jumped; the next PC is always instr_addr + 1.
  assign unused_pc_l = bus.pc_l;

  // Next sequential fetch address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_q <= '0;
    else     addr_q <= bus.instr_addr + MINSTW'(1);
  end

  // Interrupt entry wins; CAL+RET together means replace the top entry.
  always_comb begin
    op = STK_IDLE;
    if (bus.itr)                         op = STK_PUSH;
    else if (bus.isp_push && bus.isp_pop) op = STK_REPL;
    else if (bus.isp_push)               op = STK_PUSH;
    else if (bus.isp_pop)                op = STK_POP;
  end

  isp_lifo #(
    .DW      (MINSTW),
    .SDEPTHW (SDEPTHW)
  ) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .op    (op),
    .wdata (addr_q),
    .top   (bus.ret_addr),
    .depth (bus.isp_depth),
    .ovf   (bus.isp_ovf),
    .unf   (bus.isp_unf)
  );

  assign bus.addr = addr_q;
endmodule

// File: tb/tb_pc_isp.sv
// Bench for pc_isp: directed scenarios plus random traffic against a queue model.
module tb_pc_isp;
  localparam int MW = 8;
  localparam int SW = 3;
  localparam int CAP = 2**SW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_isp_if #(.MINSTW(MW), .SDEPTHW(SW)) bus ();

  pc_isp #(.MINSTW(MW), .SDEPTHW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int m_addr;
  int m_stk[$];
  bit m_ovf;
  bit m_unf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = 0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_push();
    if (m_stk.size() == CAP) m_ovf = 1'b1;
    else m_stk.push_back(m_addr);
  endtask

  task automatic check_model(input string tag);
    int exp_ret;
    exp_ret = (m_stk.size() > 0) ? m_stk[$] : 0;
    check_eq({tag, ".addr"},  32'(bus.addr),      32'(m_addr));
    check_eq({tag, ".ret"},   32'(bus.ret_addr),  32'(exp_ret));
    check_eq({tag, ".depth"}, 32'(bus.isp_depth), 32'(m_stk.size()));
    check_eq({tag, ".ovf"},   32'(bus.isp_ovf),   32'(m_ovf));
    check_eq({tag, ".unf"},   32'(bus.isp_unf),   32'(m_unf));
  endtask

  // Apply one cycle of inputs, advance the model, then compare just after the edge.
  task automatic step(input string tag, input logic [MW-1:0] ia, input logic pu,
                      input logic po, input logic it, input logic pl);
    bus.instr_addr = ia;
    bus.isp_push   = pu;
    bus.isp_pop    = po;
    bus.itr        = it;
    bus.pc_l       = pl;
    if (it) model_push();
    else if (pu && po) begin
      if (m_stk.size() == 0) m_stk.push_back(m_addr);
      else m_stk[m_stk.size()-1] = m_addr;
    end else if (pu) model_push();
    else if (po) begin
      if (m_stk.size() == 0) m_unf = 1'b1;
      else void'(m_stk.pop_back());
    end
    m_addr = (int'(ia) + 1) % (2**MW);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  // Reset pulse placed between clock edges; outputs must clear without a clock.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    check_model(tag);
    rst = 1'b0;
  endtask

  initial begin
    bus.instr_addr = '0;
    bus.isp_push   = 1'b0;
    bus.isp_pop    = 1'b0;
    bus.itr        = 1'b0;
    bus.pc_l       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rst = 1'b0;

    // reset release, PC follows instr_addr + 1
    step("rel0", 8'd0, 0, 0, 0, 0);
    check_eq("rel0.addr_k", 32'(bus.addr), 32'd1);
    step("rel1", 8'd1, 0, 0, 0, 1);
    check_eq("rel1.addr_k", 32'(bus.addr), 32'd2);
    step("rel2", 8'd2, 0, 0, 0, 0);
    check_eq("rel2.addr_k", 32'(bus.addr), 32'd3);
    check_eq("rel2.ret_k",  32'(bus.ret_addr), 32'd0);

    // push 0x10, pop two cycles later
    step("p0", 8'h0f, 0, 0, 0, 0);
    step("push10", 8'h20, 1, 0, 0, 0);
    check_eq("push10.ret_k",   32'(bus.ret_addr),  32'h10);
    check_eq("push10.depth_k", 32'(bus.isp_depth), 32'd1);
    step("idle", 8'h21, 0, 0, 0, 0);
    step("pop10", 8'h22, 0, 1, 0, 0);
    check_eq("pop10.depth_k", 32'(bus.isp_depth), 32'd0);
    check_eq("pop10.ret_k",   32'(bus.ret_addr),  32'd0);

    // nine pushes of addr 1..9 into an 8-deep stack
    pulse_reset("rst_a");
    step("pre", 8'd0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) step("fill", 8'(i), 1, 0, 0, 1);
    check_eq("ovf.depth_k", 32'(bus.isp_depth), 32'd8);
    check_eq("ovf.flag_k",  32'(bus.isp_ovf),   32'd1);
    check_eq("ovf.ret_k",   32'(bus.ret_addr),  32'd8);

    // three pops to depth 5, then an async reset between edges
    for (int i = 0; i < 3; i++) step("drain", 8'h40, 0, 1, 0, 0);
    check_eq("d5.depth_k", 32'(bus.isp_depth), 32'd5);
    pulse_reset("rst_async");
    check_eq("rst_async.depth_k", 32'(bus.isp_depth), 32'd0);
    check_eq("rst_async.ovf_k",   32'(bus.isp_ovf),   32'd0);
    step("resume", 8'h7e, 0, 0, 0, 0);
    check_eq("resume.addr_k", 32'(bus.addr), 32'h7f);

    // pop on empty sets a sticky underflow
    step("unf", 8'h50, 0, 1, 0, 0);
    check_eq("unf.flag_k", 32'(bus.isp_unf), 32'd1);
    for (int i = 0; i < 10; i++) step("unf_hold", 8'(8'h51 + i), 0, 0, 0, 0);
    check_eq("unf_hold.flag_k", 32'(bus.isp_unf), 32'd1);

    // itr with pop at depth 2: itr wins
    pulse_reset("rst_b");
    step("c0", 8'h10, 1, 0, 0, 0);
    step("c1", 8'h32, 1, 0, 0, 0);
    step("itr", 8'h60, 0, 1, 1, 1);
    check_eq("itr.depth_k", 32'(bus.isp_depth), 32'd3);
    check_eq("itr.ret_k",   32'(bus.ret_addr),  32'h33);

    // replace on non-empty and on empty
    step("repl", 8'h70, 1, 1, 0, 0);
    check_eq("repl.depth_k", 32'(bus.isp_depth), 32'd3);
    check_eq("repl.ret_k",   32'(bus.ret_addr),  32'h61);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [MW-1:0] ia;
      logic pu, po, it, pl;
      ia = MW'($urandom);
      pu = ($urandom_range(0, 99) < 40);
      po = ($urandom_range(0, 99) < 40);
      it = ($urandom_range(0, 99) < 8);
      pl = 1'($urandom);
      if ($urandom_range(0, 99) < 2) pulse_reset("rnd_rst");
      step("rnd", ia, pu, po, it, pl);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pc_isp.md
PC_ISP -- requirements
Module: pc_isp

Interface
REQ-001 SHALL have parameter MINSTW, default 8: instruction address width in bits.
REQ-002 SHALL have parameter SDEPTHW, default 3: log2 of return-stack depth, so depth is 2**SDEPTHW entries.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port instr_addr  input  MINSTW  address the prefetch stage is fetching this cycle.
REQ-006 SHALL have port pc_l  input  1  the prefetch stage is loading a non-sequential address.
REQ-007 SHALL have port isp_push  input  1  CAL: push a return address.
REQ-008 SHALL have port isp_pop  input  1  RET: pop a return address.
REQ-009 SHALL have port itr  input  1  interrupt entry this cycle.
REQ-010 SHALL have port addr  output  MINSTW  registered program counter (next sequential fetch address), fed back to prefetch.
REQ-011 SHALL have port ret_addr  output  MINSTW  registered top-of-stack value, used as the RET target.
REQ-012 SHALL have port isp_depth  output  SDEPTHW+1  number of valid stack entries.
REQ-013 SHALL have port isp_ovf  output  1  sticky overflow flag.
REQ-014 SHALL have port isp_unf  output  1  sticky underflow flag.

Function
REQ-015 SHALL update addr every cycle as addr <= instr_addr + 1, modulo 2**MINSTW, whether or not pc_l is set.
REQ-016 SHALL treat pc_l as informational only; the next-PC arithmetic SHALL depend on instr_addr alone.
REQ-017 SHALL, on a push with the stack not full, write the current addr value (before the edge) at index isp_depth and increment isp_depth; latency to ret_addr is 1 cycle.
REQ-018 SHALL, on a pop with the stack not empty, decrement isp_depth, and SHALL show the new top on ret_addr on the next cycle.
REQ-019 SHALL drive ret_addr to 0 whenever isp_depth is 0.
REQ-020 SHALL, when itr is 1, push addr (the interrupt return point) and ignore isp_push and isp_pop in that cycle; itr has priority.
REQ-021 SHALL treat isp_push and isp_pop asserted together without itr as a replace of the top entry with addr, isp_depth unchanged; if the stack is empty this is a plain push.
REQ-022 SHALL, on a push when isp_depth equals 2**SDEPTHW (full): drop the write, hold isp_depth, and set isp_ovf.
REQ-023 SHALL, on a pop when isp_depth equals 0 (empty): hold isp_depth at 0, keep ret_addr at 0, and set isp_unf.
REQ-024 SHALL keep isp_ovf and isp_unf set until reset; nothing else clears them.
REQ-025 SHALL leave stack contents unchanged in cycles with no push, pop or itr.

Reset
REQ-026 SHALL, while rst is 1, asynchronously force addr=0, ret_addr=0, isp_depth=0, isp_ovf=0 and isp_unf=0.
REQ-027 SHALL, on reset asserted mid-operation, discard all pending stack contents; entry data need not be cleared, but it SHALL be unobservable because depth is 0.
REQ-028 SHALL resume with addr = instr_addr + 1 on the first rising edge after rst deasserts.

Structure
REQ-029 SHALL take MINSTW, ITRADD and the opcode constants (JIZ=5, JMP=6, CAL=7, RET=8) from the shared parameter include used by prefetch; SDEPTHW is local to this block.
REQ-030 SHALL implement the stack as one sub-module, isp_lifo, containing the register array, depth counter, full/empty logic and flags; pc_isp holds the PC register and the push/pop/itr arbitration.

Verification
REQ-031 Bench SHALL apply: reset release with instr_addr stepping 0,1,2 -> addr 1,2,3, ret_addr 0, isp_depth 0.
REQ-032 Bench SHALL apply: addr=0x10 with isp_push, then pop two cycles later -> ret_addr=0x10 and isp_depth=1 after the push; isp_depth=0 and ret_addr=0 after the pop.
REQ-033 Bench SHALL apply: 9 pushes with SDEPTHW=3 (addr 1..9) -> isp_depth saturates at 8, isp_ovf=1 after the 9th push, ret_addr=8.
REQ-034 Bench SHALL apply: pop on empty -> isp_unf=1, isp_depth=0, ret_addr=0; the flag stays set through 10 idle cycles.
REQ-035 Bench SHALL apply: itr with isp_pop at depth 2, addr=0x33 -> isp_depth=3, ret_addr=0x33, no pop performed.
REQ-036 Bench SHALL apply: async rst pulse between clock edges at depth 5 with isp_ovf set -> all outputs 0 immediately, without waiting for a clock edge.
